// File: rtl/nubus_pkg.sv
// Shared types and helpers for the NuBus slave responder.
// Contents: status codes driven on {/TM1,/TM0} during ACK, the transfer-mode
// code {/TM0, /AD1, /AD0}, the byte-select decode function and the slot-space
// base nibble.
package nubus_pkg;

  typedef enum logic [1:0] {
    ST_TRY_AGAIN = 2'b00,
    ST_TIMEOUT   = 2'b01,
    ST_ERROR     = 2'b10,
    ST_COMPLETE  = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    MODE_BYTE3 = 3'b000,
    MODE_BYTE2 = 3'b001,
    MODE_BYTE1 = 3'b010,
    MODE_BYTE0 = 3'b011,
    MODE_HALF1 = 3'b100,
    MODE_BLOCK = 3'b101,
    MODE_HALF0 = 3'b110,
    MODE_WORD  = 3'b111
  } mode_t;

  typedef struct packed {
    logic       block;
    logic [3:0] sel;
  } sel_t;

  localparam logic [3:0] SLOT_BASE = 4'hF;

  // Mode code is built from the raw active-low lines, so H=1 and L=0.
  function automatic sel_t mode_to_sel(input logic tm0_n, input logic [1:0] ad_n);
    sel_t r;
    r.block = 1'b0;
    r.sel   = 4'b0000;
    case ({tm0_n, ad_n})
      MODE_BYTE3: r.sel = 4'b1000;
      MODE_BYTE2: r.sel = 4'b0100;
      MODE_BYTE1: r.sel = 4'b0010;
      MODE_BYTE0: r.sel = 4'b0001;
      MODE_HALF1: r.sel = 4'b1100;
      MODE_HALF0: r.sel = 4'b0011;
      MODE_WORD:  r.sel = 4'b1111;
      default:    r.block = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nubus_tm_decode.sv
// Combinational decode of the sampled NuBus address/TM lines.
// Ports:
//   id_n      in  slot ID, active-low
//   ad_n      in  sampled /AD
//   tm1_n     in  sampled /TM1 (low = write)
//   tm0_n     in  sampled /TM0
//   claim     out address falls in this card's slot (or superslot) space
//   is_write  out transfer is a write
//   block     out block-transfer mode, which this card refuses
//   sel       out byte enables for the internal bus
//   addr      out word address (A[31:2])
module nubus_tm_decode
  import nubus_pkg::*;
#(
  parameter int ENABLE_SUPERSLOT = 0
) (
  input  logic [3:0]  id_n,
  input  logic [31:0] ad_n,
  input  logic        tm1_n,
  input  logic        tm0_n,
  output logic        claim,
  output logic        is_write,
  output logic        block,
  output logic [3:0]  sel,
  output logic [29:0] addr
);

  logic [31:0] a;
  logic [3:0]  id;
  sel_t        ms;

  assign a  = ~ad_n;
  assign id = ~id_n;
  assign ms = mode_to_sel(tm0_n, ad_n[1:0]);

  assign claim    = (a[31:24] == {SLOT_BASE, id}) ||
                    ((ENABLE_SUPERSLOT != 0) && (a[31:28] == id));
  assign is_write = ~tm1_n;
  assign block    = ms.block;
  assign sel      = ms.sel;
  assign addr     = a[31:2];

endmodule

// File: rtl/nubus_slave_responder.sv
// NuBus slave responder: qualifies START, claims slot-space addresses, runs
// one access on the internal req/ack bus and answers with a one-cycle ACK
// carrying the status code (and read data for reads).
// Ports:
//   sys_clk, sys_rst           NuBus clock, synchronous active-high reset
//   id_n, start_n, ack_n       slot ID and sampled /START, /ACK
//   tm1_n, tm0_n, ad_n_i       sampled /TM1, /TM0, /AD
//   ad_n_o, ad_oe              /AD drive value and enable
//   tm_o_n, tmx_oe             {/TM1,/TM0} status drive value and enable
//   ack_o_n, ack_oe            /ACK drive value and enable
//   bus_req/we/addr/sel/wdata  internal access request
//   bus_rdata, bus_ack, bus_err internal access response
module nubus_slave_responder
  import nubus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES   = 255,
  parameter int ENABLE_SUPERSLOT = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  id_n,
  input  logic        start_n,
  input  logic        ack_n,
  input  logic        tm1_n,
  input  logic        tm0_n,
  input  logic [31:0] ad_n_i,
  output logic [31:0] ad_n_o,
  output logic        ad_oe,
  output logic [1:0]  tm_o_n,
  output logic        tmx_oe,
  output logic        ack_o_n,
  output logic        ack_oe,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WDATA, BUS, ACK} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer;
  status_t       status;
  logic          is_read;
  logic [31:0]   rdata;

  logic        claim, is_write, block;
  logic [3:0]  sel;
  logic [29:0] addr;
  logic        start_ok;
  logic        expired;

  nubus_tm_decode #(.ENABLE_SUPERSLOT(ENABLE_SUPERSLOT)) u_dec (
    .id_n     (id_n),
    .ad_n     (ad_n_i),
    .tm1_n    (tm1_n),
    .tm0_n    (tm0_n),
    .claim    (claim),
    .is_write (is_write),
    .block    (block),
    .sel      (sel),
    .addr     (addr)
  );

  // START with /ACK also low is an attention cycle, not a transaction.
  assign start_ok = ~start_n & ack_n & claim;
  assign expired  = (timer == T_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      timer     <= '0;
      status    <= ST_COMPLETE;
      is_read   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          timer <= '0;
          if (start_ok) begin
            is_read <= ~is_write;
            status  <= block ? ST_ERROR : ST_COMPLETE;
            if (!block) begin
              bus_we   <= is_write;
              bus_addr <= addr;
              bus_sel  <= sel;
            end
          end
        end
        WDATA: begin
          timer     <= '0;
          bus_wdata <= ~ad_n_i;
        end
        BUS: begin
          // A late bus_ack on the expiry cycle still counts as a response.
          if (bus_ack)      status <= bus_err ? ST_ERROR : ST_COMPLETE;
          else if (expired) status <= ST_TIMEOUT;
          else              timer  <= timer + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (state == BUS && bus_ack && !bus_err && is_read) rdata <= bus_rdata;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = block ? ACK : (is_write ? WDATA : BUS);
      WDATA:   state_nx = BUS;
      BUS:     if (bus_ack || expired) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus_req = (state == BUS);
  assign ack_oe  = (state == ACK);
  assign tmx_oe  = (state == ACK);
  assign ack_o_n = ~(state == ACK);
  assign tm_o_n  = (state == ACK) ? status : 2'b11;
  assign ad_oe   = (state == ACK) && is_read;
  // Failed reads still turn the transceivers around but present no data.
  assign ad_n_o  = (state == ACK && is_read && status == ST_COMPLETE) ? ~rdata : '1;

endmodule

// File: tb/tb_nubus_slave_responder.sv
// Directed bench for the NuBus slave responder (slot ID C, timeout 8 cycles).
module tb_nubus_slave_responder;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  id_n = 4'h3;
  logic        start_n = 1'b1, ack_n = 1'b1, tm1_n = 1'b1, tm0_n = 1'b1;
  logic [31:0] ad_n_i = '1;
  logic [31:0] ad_n_o;
  logic        ad_oe;
  logic [1:0]  tm_o_n;
  logic        tmx_oe, ack_o_n, ack_oe;
  logic        bus_req, bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0, bus_err = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  nubus_slave_responder #(.TIMEOUT_CYCLES(8), .ENABLE_SUPERSLOT(0)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .id_n(id_n), .start_n(start_n),
    .ack_n(ack_n), .tm1_n(tm1_n), .tm0_n(tm0_n), .ad_n_i(ad_n_i),
    .ad_n_o(ad_n_o), .ad_oe(ad_oe), .tm_o_n(tm_o_n), .tmx_oe(tmx_oe),
    .ack_o_n(ack_o_n), .ack_oe(ack_oe), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_start(input logic [31:0] addr, input logic t1, input logic t0);
    start_n = 1'b0; ack_n = 1'b1; tm1_n = t1; tm0_n = t0; ad_n_i = ~addr;
  endtask

  task automatic idle_lines;
    start_n = 1'b1; ack_n = 1'b1; tm1_n = 1'b1; tm0_n = 1'b1; ad_n_i = '1;
  endtask

  task automatic test_reset;
    sys_rst = 1'b1; idle_lines();
    tick(); tick();
    checks++; if ({ad_oe, tmx_oe, ack_oe, bus_req, bus_we} !== 5'b0) begin errors++; $display("FAIL reset_enables got %b exp 00000", {ad_oe, tmx_oe, ack_oe, bus_req, bus_we}); end
    checks++; if ({ack_o_n, tm_o_n} !== 3'b111) begin errors++; $display("FAIL reset_ack_tm got %b exp 111", {ack_o_n, tm_o_n}); end
    checks++; if (ad_n_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_ad_n_o got %h exp ffffffff", ad_n_o); end
    checks++; if ({bus_addr, bus_sel, bus_wdata} !== 66'd0) begin errors++; $display("FAIL reset_bus got %h %b %h exp 0", bus_addr, bus_sel, bus_wdata); end
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_write_word;
    drive_start(32'hFC000000, 1'b0, 1'b1);
    tick();                                  // cycle 1: write data phase
    start_n = 1'b1; ad_n_i = ~32'h87654321;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL wr_c1_req got %b exp 0", bus_req); end
    tick();                                  // cycle 2: internal access
    idle_lines();
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin errors++; $display("FAIL wr_req_we got %b%b exp 11", bus_req, bus_we); end
    checks++; if (bus_addr !== 30'h3F000000) begin errors++; $display("FAIL wr_addr got %h exp 3f000000", bus_addr); end
    checks++; if (bus_sel !== 4'b1111) begin errors++; $display("FAIL wr_sel got %b exp 1111", bus_sel); end
    checks++; if (bus_wdata !== 32'h87654321) begin errors++; $display("FAIL wr_wdata got %h exp 87654321", bus_wdata); end
    bus_ack = 1'b1;
    tick();                                  // cycle 3: ACK
    bus_ack = 1'b0;
    checks++; if ({ack_oe, tmx_oe, ack_o_n, tm_o_n, ad_oe} !== 6'b110110) begin errors++; $display("FAIL wr_ack got %b exp 110110", {ack_oe, tmx_oe, ack_o_n, tm_o_n, ad_oe}); end
    tick();
    checks++; if ({ack_oe, tmx_oe, ad_oe, ack_o_n} !== 4'b0001) begin errors++; $display("FAIL wr_release got %b exp 0001", {ack_oe, tmx_oe, ad_oe, ack_o_n}); end
  endtask

  task automatic test_read_word;
    drive_start(32'hFC000000, 1'b1, 1'b1);
    tick();                                  // cycle 1
    idle_lines();
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_sel !== 4'b1111) begin errors++; $display("FAIL rd_req got req=%b we=%b sel=%b exp 1 0 1111", bus_req, bus_we, bus_sel); end
    bus_ack = 1'b1; bus_rdata = 32'h87654321;
    tick();                                  // cycle 2: ACK
    bus_ack = 1'b0;
    checks++; if ({ack_oe, ad_oe, tm_o_n} !== 4'b1111) begin errors++; $display("FAIL rd_ack got %b exp 1111", {ack_oe, ad_oe, tm_o_n}); end
    checks++; if (ad_n_o !== 32'h789ABCDE) begin errors++; $display("FAIL rd_data got %h exp 789abcde", ad_n_o); end
    tick();
    checks++; if (ad_oe !== 1'b0 || ack_oe !== 1'b0 || ad_n_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL rd_release got oe=%b ack_oe=%b ad=%h exp 0 0 ffffffff", ad_oe, ack_oe, ad_n_o); end
  endtask

  task automatic test_modes;
    logic [31:0] addrs [3] = '{32'hFC000010, 32'hFC000013, 32'hFC000023};
    logic        t1s   [3] = '{1'b0, 1'b0, 1'b1};
    logic        t0s   [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0]  sels  [3] = '{4'b0001, 4'b1100, 4'b1000};
    logic [29:0] badr  [3] = '{30'h3F000004, 30'h3F000004, 30'h3F000008};
    for (int i = 0; i < 3; i++) begin
      drive_start(addrs[i], t1s[i], t0s[i]);
      tick();
      if (t1s[i] == 1'b0) begin
        start_n = 1'b1; ad_n_i = ~32'hA5A50000;
        tick();
      end
      idle_lines();
      checks++; if (bus_req !== 1'b1 || bus_sel !== sels[i] || bus_addr !== badr[i]) begin errors++; $display("FAIL mode%0d got req=%b sel=%b addr=%h exp 1 %b %h", i, bus_req, bus_sel, bus_addr, sels[i], badr[i]); end
      bus_ack = 1'b1; bus_rdata = 32'h11223344;
      tick();
      bus_ack = 1'b0;
      checks++; if (ack_oe !== 1'b1 || tm_o_n !== 2'b11 || ad_oe !== t1s[i]) begin errors++; $display("FAIL mode%0d_ack got ack_oe=%b tm=%b ad_oe=%b exp 1 11 %b", i, ack_oe, tm_o_n, ad_oe, t1s[i]); end
      tick();
    end
  endtask

  task automatic test_ignore;
    drive_start(32'hFB000000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_lines();
      checks++; if ({bus_req, ad_oe, ack_oe, tmx_oe} !== 4'b0) begin errors++; $display("FAIL foreign_addr c%0d got %b exp 0000", i, {bus_req, ad_oe, ack_oe, tmx_oe}); end
    end
    drive_start(32'hFC000000, 1'b1, 1'b1);
    ack_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_lines();
      checks++; if ({bus_req, ad_oe, ack_oe, tmx_oe} !== 4'b0) begin errors++; $display("FAIL attention c%0d got %b exp 0000", i, {bus_req, ad_oe, ack_oe, tmx_oe}); end
    end
  endtask

  task automatic test_timeout;
    drive_start(32'hFC000000, 1'b1, 1'b1);
    tick();
    idle_lines();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL timeout_req c%0d got %b exp 1", i + 1, bus_req); end
      tick();
    end
    checks++; if (bus_req !== 1'b0 || ack_oe !== 1'b1 || tm_o_n !== 2'b01) begin errors++; $display("FAIL timeout_ack got req=%b ack_oe=%b tm=%b exp 0 1 01", bus_req, ack_oe, tm_o_n); end
    checks++; if (ad_oe !== 1'b1 || ad_n_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL timeout_ad got oe=%b ad=%h exp 1 ffffffff", ad_oe, ad_n_o); end
    tick();
    checks++; if (ack_oe !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL timeout_release got ack_oe=%b req=%b exp 0 0", ack_oe, bus_req); end
  endtask

  task automatic test_error;
    drive_start(32'hFC000004, 1'b0, 1'b1);
    tick();
    start_n = 1'b1; ad_n_i = ~32'hDEADBEEF;
    tick();
    idle_lines();
    bus_ack = 1'b1; bus_err = 1'b1;
    tick();
    bus_ack = 1'b0; bus_err = 1'b0;
    checks++; if (ack_oe !== 1'b1 || tm_o_n !== 2'b10 || ad_oe !== 1'b0) begin errors++; $display("FAIL err_ack got ack_oe=%b tm=%b ad_oe=%b exp 1 10 0", ack_oe, tm_o_n, ad_oe); end
    tick();
  endtask

  task automatic test_block;
    drive_start(32'hFC000002, 1'b1, 1'b1);   // {tm0_n, ad_n[1:0]} = 101
    tick();
    idle_lines();
    checks++; if (bus_req !== 1'b0 || ack_oe !== 1'b1 || tm_o_n !== 2'b10) begin errors++; $display("FAIL block_ack got req=%b ack_oe=%b tm=%b exp 0 1 10", bus_req, ack_oe, tm_o_n); end
    checks++; if (ad_oe !== 1'b1 || ad_n_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL block_ad got oe=%b ad=%h exp 1 ffffffff", ad_oe, ad_n_o); end
    tick();
    checks++; if (bus_req !== 1'b0 || ack_oe !== 1'b0) begin errors++; $display("FAIL block_after got req=%b ack_oe=%b exp 0 0", bus_req, ack_oe); end
  endtask

  task automatic test_reset_mid;
    drive_start(32'hFC000000, 1'b1, 1'b1);
    tick();
    idle_lines();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b exp 1", bus_req); end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    checks++; if ({bus_req, ad_oe, ack_oe, tmx_oe} !== 4'b0 || bus_addr !== 30'd0 || bus_sel !== 4'd0) begin errors++; $display("FAIL rst_mid got %b addr=%h sel=%b exp 0000 0 0", {bus_req, ad_oe, ack_oe, tmx_oe}, bus_addr, bus_sel); end
    tick();
    checks++; if (bus_req !== 1'b0 || ack_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got req=%b ack_oe=%b exp 0 0", bus_req, ack_oe); end
    drive_start(32'hFC000008, 1'b1, 1'b1);
    tick();
    idle_lines();
    checks++; if (bus_req !== 1'b1 || bus_addr !== 30'h3F000002) begin errors++; $display("FAIL rst_new_req got req=%b addr=%h exp 1 3f000002", bus_req, bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h0F0F0F0F;
    tick();
    bus_ack = 1'b0;
    checks++; if (ack_oe !== 1'b1 || tm_o_n !== 2'b11 || ad_n_o !== 32'hF0F0F0F0) begin errors++; $display("FAIL rst_new_ack got ack_oe=%b tm=%b ad=%h exp 1 11 f0f0f0f0", ack_oe, tm_o_n, ad_n_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_word();
    test_read_word();
    test_modes();
    test_ignore();
    test_timeout();
    test_error();
    test_block();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
